// File: rtl/vga_board_renderer.sv
// Board-to-pixel renderer: frame-locked shadow copy of the 16x16 board, then a
// 2-stage pipeline that turns display timing into 12-bit RGB with grid lines and a blinking cursor.
module vga_board_renderer #(
   parameter int GRID_X0    = 336,
   parameter int GRID_Y0    = 147,
   parameter int CELL_SHIFT = 4,
   parameter int V_SNAP     = 515,
   parameter int BLINK_BIT  = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bright,
   input  logic [9:0]   hCount,
   input  logic [9:0]   vCount,
   input  logic [255:0] board,
   input  logic         cursor_en,
   input  logic [3:0]   cursor_row,
   input  logic [3:0]   cursor_col,
   output logic [11:0]  rgb,
   output logic         frame_tick
);

   localparam int         GRID_SPAN = 16 << CELL_SHIFT;
   localparam logic [9:0] X0        = 10'(GRID_X0);
   localparam logic [9:0] Y0        = 10'(GRID_Y0);
   localparam logic [9:0] VS        = 10'(V_SNAP);
   localparam logic [9:0] SPAN      = 10'(GRID_SPAN);

   logic [255:0]          shadow;
   logic [4:0]            frame_cnt;
   logic                  snap_done;
   logic                  snap_fire;

   logic [9:0]            dx, dy;
   logic                  cur_hit;

   logic                  vis_p1;
   logic                  in_grid_p1;
   logic                  cur_hit_p1;
   logic [3:0]            row_p1, col_p1;
   logic [CELL_SHIFT-1:0] ox_p1, oy_p1;

   // Colour priority: blanking, outside grid, cursor frame, grid line, cell state.
   function automatic logic [11:0] cell_colour(
      input logic vis,
      input logic in_grid,
      input logic cur_hit_in,
      input logic edge_any,
      input logic line,
      input logic alive
   );
      if (!vis || !in_grid)        return 12'h000;
      if (cur_hit_in && edge_any)  return 12'hFF0;
      if (line)                    return 12'h444;
      if (alive)                   return 12'h0F0;
      return 12'h111;
   endfunction

   // hCount sits at 0 for several clocks on the snap line; snap_done keeps it to one capture.
   assign snap_fire  = (vCount == VS) && (hCount == 10'd0) && !snap_done && !reset;
   assign frame_tick = snap_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow    <= '0;
         frame_cnt <= '0;
         snap_done <= 1'b0;
      end else if (snap_fire) begin
         shadow    <= board;
         frame_cnt <= frame_cnt + 5'd1;
         snap_done <= 1'b1;
      end else if (vCount != VS) begin
         snap_done <= 1'b0;
      end
   end

   // Unsigned wrap makes coordinates left of / above the grid look huge, hence outside.
   assign dx      = hCount - X0;
   assign dy      = vCount - Y0;
   assign cur_hit = cursor_en
                    && (dy[CELL_SHIFT +: 4] == cursor_row)
                    && (dx[CELL_SHIFT +: 4] == cursor_col)
                    && !frame_cnt[BLINK_BIT];

   // ---- stage 1: geometry ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vis_p1     <= 1'b0;
         in_grid_p1 <= 1'b0;
         cur_hit_p1 <= 1'b0;
         row_p1     <= '0;
         col_p1     <= '0;
         ox_p1      <= '0;
         oy_p1      <= '0;
      end else begin
         vis_p1     <= bright;
         in_grid_p1 <= (dx < SPAN) && (dy < SPAN);
         cur_hit_p1 <= cur_hit;
         row_p1     <= dy[CELL_SHIFT +: 4];
         col_p1     <= dx[CELL_SHIFT +: 4];
         ox_p1      <= dx[CELL_SHIFT-1:0];
         oy_p1      <= dy[CELL_SHIFT-1:0];
      end
   end

   // ---- stage 2: colour ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb <= 12'h000;
      end else begin
         rgb <= cell_colour(vis_p1, in_grid_p1, cur_hit_p1,
                            (ox_p1 == '0) || (ox_p1 == '1) || (oy_p1 == '0) || (oy_p1 == '1),
                            (ox_p1 == '0) || (oy_p1 == '0),
                            shadow[{row_p1, col_p1}]);
      end
   end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a pixel-rule reference model.
module tb_vga_board_renderer;

   logic         clk = 1'b0;
   logic         reset;
   logic         bright;
   logic [9:0]   hcount, vcount;
   logic [255:0] board;
   logic         cursor_en;
   logic [3:0]   cursor_row, cursor_col;
   logic [11:0]  rgb;
   logic         frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [255:0] m_shadow;
   int           m_cnt;
   bit           m_done;
   logic [11:0]  m_pend, m_rgb;
   bit           last_tick;

   typedef struct {
      logic        b;
      int          h;
      int          v;
      logic        cen;
      int          cr;
      int          cc;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[14];

   vga_board_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .bright     (bright),
      .hCount     (hcount),
      .vCount     (vcount),
      .board      (board),
      .cursor_en  (cursor_en),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .rgb        (rgb),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pixel colour straight from the drawing rules, with plain integer geometry.
   function automatic logic [11:0] model_pixel(input logic b, input int h, input int v,
                                               input logic cen, input int cr, input int cc);
      int x, y, row, col, ox, oy;
      bit on_edge;
      x = h - 336;
      y = v - 147;
      if (!b) return 12'h000;
      if (x < 0 || x >= 256 || y < 0 || y >= 256) return 12'h000;
      row = y / 16; col = x / 16; ox = x % 16; oy = y % 16;
      on_edge = (ox == 0) || (oy == 0) || (ox == 15) || (oy == 15);
      if (cen && row == cr && col == cc && ((m_cnt / 16) % 2 == 0) && on_edge) return 12'hFF0;
      if (ox == 0 || oy == 0) return 12'h444;
      if (m_shadow[row * 16 + col]) return 12'h0F0;
      return 12'h111;
   endfunction

   task automatic m_reset();
      m_shadow = '0; m_cnt = 0; m_done = 0; m_pend = 12'h000; m_rgb = 12'h000;
   endtask

   task automatic blank();
      bright = 1'b0; hcount = 10'd0; vcount = 10'd0;
   endtask

   // One clock with the inputs currently driven; called at posedge+1, returns at posedge+1.
   task automatic step();
      bit fire;
      logic [11:0] c;
      fire = (vcount == 10'd515) && (hcount == 10'd0) && !m_done;
      @(negedge clk);
      last_tick = frame_tick;
      check("frame_tick", {11'd0, frame_tick}, {11'd0, fire});
      c = model_pixel(bright, int'(hcount), int'(vcount), cursor_en, int'(cursor_row), int'(cursor_col));
      @(posedge clk);
      m_rgb  = m_pend;
      m_pend = c;
      if (fire) begin
         m_shadow = board; m_cnt = (m_cnt + 1) % 32; m_done = 1;
      end else if (vcount != 10'd515) begin
         m_done = 0;
      end
      #1;
      check("rgb_model", rgb, m_rgb);
   endtask

   task automatic show(input logic b, input int h, input int v, input logic cen, input int cr, input int cc);
      bright = b; hcount = 10'(h); vcount = 10'(v);
      cursor_en = cen; cursor_row = 4'(cr); cursor_col = 4'(cc);
      step();
      blank();
      step();
   endtask

   task automatic pixel(input string nm, input logic b, input int h, input int v,
                        input logic cen, input int cr, input int cc, input logic [11:0] exp);
      show(b, h, v, cen, cr, cc);
      check(nm, rgb, exp);
   endtask

   task automatic snap(input int hold);
      int ticks;
      ticks = 0;
      bright = 1'b0; vcount = 10'd515; hcount = 10'd0;
      repeat (hold) begin
         step();
         ticks += int'(last_tick);
      end
      vcount = 10'd516; hcount = 10'd1;
      step();
      ticks += int'(last_tick);
      check("tick_count", 12'(ticks), 12'd1);
      blank();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 337, 148, 1'b0, 0, 0, 12'h0F0};
      vecs[1]  = '{1'b1, 336, 148, 1'b0, 0, 0, 12'h444};
      vecs[2]  = '{1'b1, 353, 148, 1'b0, 0, 0, 12'h111};
      vecs[3]  = '{1'b1, 335, 148, 1'b0, 0, 0, 12'h000};
      vecs[4]  = '{1'b0, 337, 148, 1'b0, 0, 0, 12'h000};
      vecs[5]  = '{1'b1, 337, 147, 1'b0, 0, 0, 12'h444};
      vecs[6]  = '{1'b1, 591, 402, 1'b0, 0, 0, 12'h0F0};
      vecs[7]  = '{1'b1, 592, 148, 1'b0, 0, 0, 12'h000};
      vecs[8]  = '{1'b1, 337, 403, 1'b0, 0, 0, 12'h000};
      vecs[9]  = '{1'b1, 384, 179, 1'b1, 2, 3, 12'hFF0};
      vecs[10] = '{1'b1, 390, 185, 1'b1, 2, 3, 12'h0F0};
      vecs[11] = '{1'b1, 399, 179, 1'b1, 2, 3, 12'hFF0};
      vecs[12] = '{1'b1, 399, 194, 1'b1, 2, 3, 12'hFF0};
      vecs[13] = '{1'b1, 384, 179, 1'b1, 2, 4, 12'h444};

      reset = 1'b1; blank(); board = '0;
      cursor_en = 1'b0; cursor_row = 4'd0; cursor_col = 4'd0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rgb", rgb, 12'h000);
      check("reset_tick", {11'd0, frame_tick}, 12'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      board = '0; board[0] = 1'b1; board[35] = 1'b1; board[255] = 1'b1;
      pixel("pre_snap_dead", 1'b1, 337, 148, 1'b0, 0, 0, 12'h111);
      snap(4);

      for (int i = 0; i < 14; i++) begin
         show(vecs[i].b, vecs[i].h, vecs[i].v, vecs[i].cen, vecs[i].cr, vecs[i].cc);
         n_tests++;
         if (rgb !== vecs[i].exp) begin
            n_fail++;
            $display("FAIL vec%0d: got %h expected %h", i, rgb, vecs[i].exp);
         end
      end

      // board edit mid-frame stays hidden until the next capture
      bright = 1'b1; hcount = 10'd337; vcount = 10'd200;
      board[0] = 1'b0;
      step();
      pixel("midframe_hold", 1'b1, 337, 148, 1'b0, 0, 0, 12'h0F0);
      snap(1);
      pixel("midframe_new", 1'b1, 337, 148, 1'b0, 0, 0, 12'h111);
      board[0] = 1'b1;
      snap(1);
      pixel("board_back", 1'b1, 337, 148, 1'b0, 0, 0, 12'h0F0);

      // frame counter now 3; blink off from 16..31, wrap at 32
      for (int i = 0; i < 13; i++) snap(1);
      pixel("blink_16", 1'b1, 384, 179, 1'b1, 2, 3, 12'h444);
      for (int i = 0; i < 15; i++) snap(1);
      pixel("blink_31", 1'b1, 384, 179, 1'b1, 2, 3, 12'h444);
      snap(1);
      pixel("wrap_32", 1'b1, 384, 179, 1'b1, 2, 3, 12'hFF0);
      snap(1);
      pixel("wrap_33", 1'b1, 384, 179, 1'b1, 2, 3, 12'hFF0);

      // bright latency: change at edge n shows after edge n+1
      cursor_en = 1'b0;
      bright = 1'b1; hcount = 10'd337; vcount = 10'd148;
      repeat (3) step();
      check("lat_on", rgb, 12'h0F0);
      bright = 1'b0;
      step();
      check("lat_n", rgb, 12'h0F0);
      step();
      check("lat_n1", rgb, 12'h000);

      // asynchronous reset in the middle of a live pixel run
      bright = 1'b1;
      step(); step();
      check("pre_reset", rgb, 12'h0F0);
      #2 reset = 1'b1;
      #1;
      check("async_reset", rgb, 12'h000);
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) begin reset = 1'b0; blank(); end
      @(posedge clk); #1;
      pixel("post_reset_dead", 1'b1, 337, 148, 1'b0, 0, 0, 12'h111);
      snap(1);
      pixel("post_reset_snap", 1'b1, 337, 148, 1'b0, 0, 0, 12'h0F0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i % 97 == 0)
            board = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (i % 50 == 0) begin
            cursor_row = 4'($urandom_range(0, 15));
            cursor_col = 4'($urandom_range(0, 15));
         end
         if (i % 53 == 0) begin
            snap(int'($urandom_range(1, 4)));
         end else begin
            bright    = ($urandom_range(0, 3) != 0);
            cursor_en = ($urandom_range(0, 2) != 0);
            hcount = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 799)) : 10'($urandom_range(320, 600));
            vcount = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 524)) : 10'($urandom_range(130, 410));
            if (vcount == 10'd515) vcount = 10'd516;
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_board_renderer.md
Name: vga_board_renderer

Overview:
- Consumer end of the board/display interface: turns the 256-bit 16x16 board from Main_machine plus the hCount/vCount/bright timing from display_controller into 12-bit RGB pixels.
- Captures a tear-free shadow copy of the board once per frame during vertical blanking.
- Draws the grid with cell borders and a blinking cursor overlay.
- Sits between the game machine, the display controller and the top-level vgaR/vgaG/vgaB pins.

Parameters:
- GRID_X0, 336, hCount of the grid's left pixel column (centres a 256 px grid in the 144..783 visible range).
- GRID_Y0, 147, vCount of the grid's top pixel row (centres the grid in the 35..514 visible range).
- CELL_SHIFT, 4, log2 of cell size in pixels (16 px cells, 256x256 px grid).
- V_SNAP, 515, vCount line on which the board snapshot is taken (first blank line).
- BLINK_BIT, 4, frame-counter bit that gates the cursor (toggles every 16 frames).

Ports:
- clk  in  1  system clock (100 MHz); all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bright  in  1  visible-area flag from display_controller.
- hCount  in  10  horizontal pixel counter.
- vCount  in  10  vertical line counter.
- board  in  256  live board; cell (r,c) = board[r*16+c], r,c in 0..15; 1 = alive.
- cursor_en  in  1  enables the cursor overlay.
- cursor_row  in  4  cursor cell row.
- cursor_col  in  4  cursor cell column.
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}, registered.
- frame_tick  out  1  one-clk pulse on the cycle the snapshot is taken.

Behaviour:
- Reset (async): shadow board = 0, frame_cnt (5 bit) = 0, snap_done = 0, all pipeline regs = 0, rgb = 12'h000, frame_tick = 0.
- Snapshot:
  - snap_cond = (vCount == V_SNAP) && (hCount == 0).
  - On the first clk with snap_cond true and snap_done = 0: shadow <= board, frame_cnt <= frame_cnt + 1 (wraps 31->0), frame_tick = 1 for that clk, snap_done <= 1.
  - snap_done clears when vCount != V_SNAP. Exactly one capture per frame even though hCount holds 0 for several clks.
  - board changes at any other time have no visible effect until the next snapshot.
- Pipeline, 2-clk latency: rgb at cycle n+2 reflects bright/hCount/vCount sampled at cycle n.
- Stage 1 registers:
  - vis = bright.
  - in_grid = (hCount - GRID_X0) < 256 && (vCount - GRID_Y0) < 256, using 10-bit unsigned subtraction; underflow wraps large and so counts as outside.
  - col = dx[7:4], row = dy[7:4], ox = dx[3:0], oy = dy[3:0].
  - cur_hit = cursor_en && row == cursor_row && col == cursor_col && frame_cnt[BLINK_BIT] == 0.
- Stage 2 colour select (rgb register), in priority order:
  - !vis -> 000
  - !in_grid -> 000
  - cur_hit && (ox==0 || ox==15 || oy==0 || oy==15) -> FF0
  - ox==0 || oy==0 -> 444 (grid line)
  - shadow[row*16+col] -> 0F0 (alive)
  - otherwise -> 111 (dead)
- Right and bottom grid edges have no line of their own; the line at offset 0 of each cell provides the borders.
- Cursor row/col/en are sampled every clk; moving the cursor mid-frame takes effect within 2 clks (tearing allowed for the cursor only).
- Reset mid-frame: rgb is forced to 000 immediately. The grid shows all-dead (111) until the next V_SNAP capture.
- No handshake with Main_machine. The frame_tick pulse is provided so a generation step can align to frames.

Test Plan:
- Reset asserted mid-line with rgb=0F0 -> rgb=000 in the same cycle; after release and one frame, grid pixels show 111 until frame_tick, then reflect board.
- board[0]=1, others 0; snapshot taken; pixel (hCount=337, vCount=148) -> rgb=0F0 two clks later; (336,148) -> 444; (353,148) -> 111; (335,148) -> 000.
- board changed at vCount=200 mid-frame -> rendered pixels unchanged for that frame; new values appear after the next frame_tick at vCount=515, hCount=0.
- hCount held at 0 for 4 clks on line 515 -> frame_tick high exactly 1 clk; frame_cnt increments by exactly 1; 33 frames -> frame_cnt wraps to 1.
- cursor_en=1, row=2, col=3, frame_cnt[4]=0 -> pixel (384,179) = FF0; after 16 frames (frame_cnt[4]=1) same pixel = 444.
- bright=0 at an in-grid coordinate with a live cell -> rgb=000; latency check: bright toggles at cycle n, rgb changes at n+2.
